// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NUM_REQ requesters.
// Accept -> EXEC (ALU driven from flops) -> RESP (valid/ready, tagged by id).
module alu_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = 32,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*3-1:0]      req_op,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    output logic [2:0]                alu_control,
    input  logic [DATA_W-1:0]         alu_result,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_err,
    output logic                      busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [ID_W:0] NREQ = (ID_W+1)'(NUM_REQ);

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     cap_id_q, cap_id_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;
    logic [2:0]          alu_op_q, alu_op_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic                busy_q, busy_d;

    logic                gnt_found;
    logic [ID_W-1:0]     gnt_id;
    logic [ID_W-1:0]     cand;
    logic                op_bad;

    // (x + k) mod NUM_REQ; both operands are below NUM_REQ
    function automatic logic [ID_W-1:0] wrap_add(
        input logic [ID_W-1:0] x,
        input logic [ID_W:0]   k
    );
        logic [ID_W:0] s;
        s = {1'b0, x} + k;
        if (s >= NREQ) s = s - NREQ;
        return s[ID_W-1:0];
    endfunction

    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = wrap_add(rr_ptr_q, (ID_W+1)'(k));
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_id    = cand;
            end
        end
    end

    // Gated by rst_n so the grant also drops immediately during reset
    always_comb begin
        req_ready = '0;
        if (rst_n && state_q == IDLE && gnt_found)
            req_ready[gnt_id] = 1'b1;
    end

    assign op_bad = (alu_op_q[2:1] == 2'b11);

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cap_id_d    = cap_id_q;
        rsp_id_d    = rsp_id_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        busy_d      = busy_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    state_d  = EXEC;
                    busy_d   = 1'b1;
                    cap_id_d = gnt_id;
                    alu_a_d  = req_a[gnt_id*DATA_W +: DATA_W];
                    alu_b_d  = req_b[gnt_id*DATA_W +: DATA_W];
                    alu_op_d = req_op[gnt_id*3 +: 3];
                end
            end
            EXEC: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_id_d    = cap_id_q;
                rsp_err_d   = op_bad;
                rsp_data_d  = op_bad ? '0 : alu_result;
                alu_a_d     = '0;
                alu_b_d     = '0;
                alu_op_d    = '0;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    rr_ptr_d    = wrap_add(rsp_id_q, (ID_W+1)'(1));
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            cap_id_q    <= '0;
            rsp_id_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cap_id_q    <= cap_id_d;
            rsp_id_q    <= rsp_id_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
        end
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_control = alu_op_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU attached.
// Expected values are hand-computed per vector.
module tb_alu_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_a;
    logic [N*DW-1:0] req_b;
    logic [N*3-1:0]  req_op;
    logic [DW-1:0]   alu_a;
    logic [DW-1:0]   alu_b;
    logic [2:0]      alu_control;
    logic [DW-1:0]   alu_result;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [DW-1:0]   rsp_data;
    logic            rsp_err;
    logic            busy;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .busy        (busy)
    );

    // Shared ALU; unsupported opcodes return junk the block must mask
    always_comb begin
        unique case (alu_control)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a - alu_b;
            3'b010:  alu_result = alu_a & alu_b;
            3'b011:  alu_result = alu_a | alu_b;
            3'b100:  alu_result = alu_a ^ alu_b;
            3'b101:  alu_result = alu_a << alu_b[4:0];
            default: alu_result = 32'hDEAD_BEEF;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, got, exp);
    endtask

    task automatic set_req(input int i, input logic [31:0] a,
                           input logic [31:0] b, input logic [2:0] op);
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
        req_op[i*3 +: 3]  = op;
    endtask

    // Called at a negedge in IDLE with req_valid already driven
    task automatic run_one(input int id, input logic [2:0] op,
                           input logic [31:0] data, input logic err,
                           input int hold);
        #1;
        chk("gnt", 32'(req_ready), 32'(1) << id);
        @(negedge clk);
        chk("exec_busy", 32'(busy), 32'd1);
        chk("exec_rdy", 32'(req_ready), 32'd0);
        chk("exec_op", 32'(alu_control), 32'(op));
        @(negedge clk);
        chk("rsp_v", 32'(rsp_valid), 32'd1);
        chk("rsp_id", 32'(rsp_id), 32'(id));
        chk("rsp_data", rsp_data, data);
        chk("rsp_err", 32'(rsp_err), 32'(err));
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            chk("hold_v", 32'(rsp_valid), 32'd1);
            chk("hold_d", rsp_data, data);
            chk("hold_id", 32'(rsp_id), 32'(id));
            chk("hold_rdy", 32'(req_ready), 32'd0);
            chk("hold_busy", 32'(busy), 32'd1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("done_v", 32'(rsp_valid), 32'd0);
        chk("done_busy", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_rdy", 32'(req_ready), 32'd0);
        chk("rst_v", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_alu", alu_a | alu_b | 32'(alu_control), 32'd0);
        chk("rst_rsp", rsp_data | 32'(rsp_id) | 32'(rsp_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // single requester, ADD 5+3
        req_valid = 4'b0001;
        set_req(0, 32'd5, 32'd3, 3'b000);
        #1;
        chk("t1_rdy", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = '0;
        chk("t1_a", alu_a, 32'd5);
        chk("t1_b", alu_b, 32'd3);
        chk("t1_v0", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("t1_v", 32'(rsp_valid), 32'd1);
        chk("t1_d", rsp_data, 32'd8);
        chk("t1_id", 32'(rsp_id), 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("t1_idle_a", alu_a, 32'd0);
        chk("t1_idle_v", 32'(rsp_valid), 32'd0);

        // all four contending: order 0,1,2,3,0
        do_reset();
        set_req(0, 32'd5, 32'd3, 3'b000);
        set_req(1, 32'd3, 32'd5, 3'b001);
        set_req(2, 32'h0000_F0F0, 32'h0000_FF00, 3'b010);
        set_req(3, 32'h0000_AAAA, 32'h0000_FFFF, 3'b100);
        req_valid = 4'b1111;
        run_one(0, 3'b000, 32'd8, 1'b0, 0);
        run_one(1, 3'b001, 32'hFFFF_FFFE, 1'b0, 0);
        run_one(2, 3'b010, 32'h0000_F000, 1'b0, 0);
        run_one(3, 3'b100, 32'h0000_5555, 1'b0, 0);
        run_one(0, 3'b000, 32'd8, 1'b0, 0);
        req_valid = '0;

        // rr_ptr=1: req0/req2 valid -> 2 wins; back-pressure 10 cycles
        set_req(2, 32'h0000_000F, 32'h0000_00F0, 3'b011);
        req_valid = 4'b0101;
        run_one(2, 3'b011, 32'h0000_00FF, 1'b0, 10);
        req_valid = '0;

        // rr_ptr=3: unsupported op, then SLL uses only b[4:0]
        set_req(1, 32'd1, 32'd1, 3'b110);
        req_valid = 4'b0010;
        run_one(1, 3'b110, 32'd0, 1'b1, 0);
        set_req(2, 32'd1, 32'h0000_0021, 3'b101);
        req_valid = 4'b0100;
        run_one(2, 3'b101, 32'd2, 1'b0, 0);

        // rr_ptr=3: req3 then wrap to 0, req1 granted right away
        set_req(3, 32'd7, 32'd8, 3'b000);
        req_valid = 4'b1000;
        run_one(3, 3'b000, 32'd15, 1'b0, 0);
        set_req(1, 32'd9, 32'd4, 3'b001);
        req_valid = 4'b0010;
        run_one(1, 3'b001, 32'd5, 1'b0, 0);

        // rr_ptr=2: reset in EXEC, then in RESP
        req_valid = 4'b0101;
        #1;
        chk("t5_gnt2", 32'(req_ready), 32'b0100);
        @(negedge clk);
        chk("t5_exec_a", alu_a, 32'd1);
        do_reset();
        #1;
        chk("t5_gnt0", 32'(req_ready), 32'b0001);
        @(negedge clk);
        @(negedge clk);
        req_valid = '0;
        chk("t5_resp_v", 32'(rsp_valid), 32'd1);
        do_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t5_no_v", 32'(rsp_valid), 32'd0);
            chk("t5_idle", 32'(busy), 32'd0);
        end
        req_valid = 4'b1010;
        run_one(1, 3'b001, 32'd5, 1'b0, 0);
        req_valid = '0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
